// File: rtl/cla_seq_add_ctrl.sv
// rtl/cla_seq_add_ctrl.sv - sequencer that adds two W-bit operands 16 bits per cycle through an external CLA
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             add request, sampled only while busy=0 (IDLE or DONE)
//   a, b, c_in        operands and carry-in, latched when start is accepted
//   busy              high in RUN while slices are being sequenced
//   done              one-cycle pulse; s/c_out are valid while it is high
//   s, c_out          registered result of the last completed addition
//   add_a/add_b/add_cin  slice operands to the external 16-bit adder (0 outside RUN)
//   add_s/add_cout    combinational result from the external adder
module cla_seq_add_ctrl #(
    parameter int SLICES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [16*SLICES-1:0]   a,
    input  logic [16*SLICES-1:0]   b,
    input  logic                   c_in,
    output logic                   busy,
    output logic                   done,
    output logic [16*SLICES-1:0]   s,
    output logic                   c_out,
    output logic [15:0]            add_a,
    output logic [15:0]            add_b,
    output logic                   add_cin,
    input  logic [15:0]            add_s,
    input  logic                   add_cout
);

    localparam int W  = 16 * SLICES;
    localparam int IW = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(SLICES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            accept;

    // DONE accepts a new start so results can be produced back-to-back.
    assign accept = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN:     state_next = (idx == LAST_IDX) ? DONE : RUN;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            s     <= '0;
            c_out <= 1'b0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b;
            carry <= c_in;
            idx   <= '0;
        end else if (state == RUN) begin
            s[16*idx +: 16] <= add_s;
            carry           <= add_cout;
            if (idx == LAST_IDX) begin
                c_out <= add_cout;
                idx   <= '0;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

    // The adder inputs are gated so the external CLA sees zeros whenever it is not in use.
    always_comb begin
        add_a   = 16'd0;
        add_b   = 16'd0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_reg[16*idx +: 16];
            add_b   = b_reg[16*idx +: 16];
            add_cin = carry;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_cla_seq_add_ctrl.sv
// tb/tb_cla_seq_add_ctrl.sv - scoreboard bench for cla_seq_add_ctrl with a behavioural external adder
module tb_cla_seq_add_ctrl;

    localparam int SLICES = 4;
    localparam int W      = 16 * SLICES;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          c_in = 1'b0;
    logic          busy;
    logic          done;
    logic [W-1:0]  s;
    logic          c_out;
    logic [15:0]   add_a;
    logic [15:0]   add_b;
    logic          add_cin;
    logic [15:0]   add_s;
    logic          add_cout;
    logic [16:0]   add_sum;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int cyc = 0;

    logic [W:0] exp_q[$];

    cla_seq_add_ctrl #(.SLICES(SLICES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .busy     (busy),
        .done     (done),
        .s        (s),
        .c_out    (c_out),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout)
    );

    assign add_sum  = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};
    assign add_s    = add_sum[15:0];
    assign add_cout = add_sum[16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every done cycle must match the oldest accepted request.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: got c_out/s %h expected no done pulse", {c_out, s});
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                if ({c_out, s} !== e) begin
                    bad++;
                    $display("FAIL result: got c_out/s %h expected %h", {c_out, s}, e);
                end
            end
        end
    end

    // One transaction from IDLE with latency checks; optionally pulses start mid-RUN.
    task automatic run_one(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                           input logic [W:0] exp, input bit interfere);
        @(negedge clk);
        a = va; b = vb; c_in = vc; start = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~va; b = {vb[W/2-1:0], vb[W-1:W/2]} ^ 64'h5A5A_A5A5_0F0F_F0F0; c_in = ~vc;
        for (int k = 1; k <= SLICES; k++) begin
            @(negedge clk);
            check("busy_in_run", {63'd0, busy, done}, {63'd0, 1'b1, 1'b0});
            if (interfere && k == 2) begin
                a = 64'h1111_2222_3333_4444; b = 64'h0F0F_0F0F_0F0F_0F0F; c_in = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        @(negedge clk);
        check("done_latency", {63'd0, busy, done}, {63'd0, 1'b0, 1'b1});
    endtask

    initial begin
        logic [W-1:0] bb_a [3];
        logic [W-1:0] bb_b [3];
        logic         bb_c [3];
        logic [W:0]   bb_e [3];
        int           n_before;
        int           last_cyc;
        int           wait_cnt;

        bb_a[0] = 64'h1234_5678_9ABC_DEF0; bb_b[0] = 64'h1111_1111_1111_1111; bb_c[0] = 1'b0;
        bb_e[0] = {1'b0, 64'h2345_6789_ABCD_F001};
        bb_a[1] = 64'h8000_0000_0000_0000; bb_b[1] = 64'h8000_0000_0000_0000; bb_c[1] = 1'b0;
        bb_e[1] = {1'b1, 64'h0};
        bb_a[2] = 64'h0123_4567_89AB_CDEF; bb_b[2] = 64'hFEDC_BA98_7654_3210; bb_c[2] = 1'b1;
        bb_e[2] = {1'b1, 64'h0};

        // Reset state.
        #2;
        check("reset_outputs", {busy, done, c_out, add_cin, 61'd0}, {65'd0});
        check("reset_s", {1'b0, s}, {65'd0});
        check("reset_adder_ops", {33'd0, add_a, add_b}, {65'd0});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_one(64'h7EBD, 64'h4191, 1'b0, {1'b0, 64'h0000_0000_0000_C04E}, 1'b0);
        run_one(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, {1'b1, 64'h0}, 1'b0);
        run_one(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, {1'b0, 64'h0000_0000_0001_0000}, 1'b0);

        // Result holds while idle.
        repeat (3) @(negedge clk);
        check("hold_after_done", {c_out, s}, {1'b0, 64'h0000_0000_0001_0000});
        check("idle_adder_ops", {32'd0, add_a, add_b, add_cin}, {65'd0});

        // Start pulsed mid-RUN is ignored: one done, first result intact.
        n_before = done_cnt;
        run_one(64'h7EBD, 64'h4191, 1'b0, {1'b0, 64'h0000_0000_0000_C04E}, 1'b1);
        repeat (6) @(negedge clk);
        check("single_done_pulse", 65'(done_cnt - n_before), 65'd1);
        check("ignored_result", {c_out, s}, {1'b0, 64'h0000_0000_0000_C04E});

        // Reset in the second RUN cycle.
        @(negedge clk);
        a = 64'hDEAD_BEEF_0000_1234; b = 64'h1; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_ctl", {busy, done, c_out, add_cin, 61'd0}, {65'd0});
        check("midrun_reset_s", {1'b0, s}, {65'd0});
        check("midrun_reset_ops", {33'd0, add_a, add_b}, {65'd0});
        n_before = done_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("no_done_after_abort", 65'(done_cnt - n_before), 65'd0);
        run_one(64'd3, 64'd4, 1'b1, {1'b0, 64'd8}, 1'b0);

        // Back-to-back with start held high.
        @(negedge clk);
        a = bb_a[0]; b = bb_b[0]; c_in = bb_c[0]; start = 1'b1;
        exp_q.push_back(bb_e[0]);
        last_cyc = -1;
        for (int k = 0; k < 3; k++) begin
            wait_cnt = 0;
            @(negedge clk);
            while (!done && wait_cnt < 20) begin
                @(negedge clk);
                wait_cnt++;
            end
            if (!done) begin
                check("bb_timeout", 65'd0, 65'd1);
                break;
            end
            if (last_cyc >= 0) check("bb_period", 65'(cyc - last_cyc), 65'(SLICES + 1));
            last_cyc = cyc;
            if (k < 2) begin
                a = bb_a[k+1]; b = bb_b[k+1]; c_in = bb_c[k+1];
                exp_q.push_back(bb_e[k+1]);
            end else begin
                start = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        check("queue_drained", 65'(exp_q.size()), 65'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
